// File: rtl/hub75_scan_ctrl.sv
// HUB75 LED panel scan controller: sequences row/plane shifts, blanking, latching and
// binary-coded-modulation display time. Optional macro HUB75_GHOST_BLANK_EN stretches BLANK to DEAD cycles.
module hub75_scan_ctrl #(
  parameter int ROW_BITS = 5,
  parameter int PLANES   = 8,
  parameter int BASE_ON  = 8,
  parameter int DEAD     = 4
) (
  input  logic                osc25m,
  input  logic                resetn,
  input  logic                enable,
  output logic                shift_start,
  output logic [ROW_BITS-1:0] shift_row,
  output logic [2:0]          shift_plane,
  input  logic                shift_done,
  output logic [ROW_BITS-1:0] panel_addr,
  output logic                panel_lat,
  output logic                panel_oe,
  output logic                frame_start,
  output logic                busy
);

  localparam int TIMER_MAX = BASE_ON << (PLANES - 1);
  localparam int TW        = $clog2(TIMER_MAX + 1);
  localparam int BW        = $clog2(DEAD + 1);
`ifdef HUB75_GHOST_BLANK_EN
  localparam int BLANK_LEN = DEAD;
`else
  localparam int BLANK_LEN = 1;
`endif
  localparam logic [2:0]    LAST_PLANE = 3'(PLANES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT,
    S_BLANK,
    S_LATCH
  } state_t;

  state_t              state_q, state_d;
  logic [ROW_BITS-1:0] nxt_row_q, nxt_row_d;
  logic [2:0]          nxt_plane_q, nxt_plane_d;
  logic [ROW_BITS-1:0] shift_row_q, shift_row_d;
  logic [2:0]          shift_plane_q, shift_plane_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [BW-1:0]       blank_cnt_q, blank_cnt_d;
  logic [ROW_BITS-1:0] panel_addr_q, panel_addr_d;
  logic                shift_start_q, shift_start_d;
  logic                frame_start_q, frame_start_d;
  logic                panel_lat_q, panel_lat_d;
  logic                panel_oe_q, panel_oe_d;
  logic                busy_q, busy_d;
  logic                issue;

  always_comb begin
    state_d       = state_q;
    nxt_row_d     = nxt_row_q;
    nxt_plane_d   = nxt_plane_q;
    shift_row_d   = shift_row_q;
    shift_plane_d = shift_plane_q;
    blank_cnt_d   = blank_cnt_q;
    panel_addr_d  = panel_addr_q;
    shift_start_d = 1'b0;
    frame_start_d = 1'b0;
    issue         = 1'b0;
    // The display timer free-runs down to zero and parks there; it never wraps.
    timer_d       = (timer_q != '0) ? timer_q - TW'(1) : timer_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          issue   = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (shift_done) begin
          if (timer_q == '0) begin
            state_d      = S_BLANK;
            blank_cnt_d  = '0;
            panel_addr_d = shift_row_q;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (timer_q == '0) begin
          state_d      = S_BLANK;
          blank_cnt_d  = '0;
          panel_addr_d = shift_row_q;
        end
      end
      S_BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          state_d = S_LATCH;
        end else begin
          blank_cnt_d = blank_cnt_q + BW'(1);
        end
      end
      S_LATCH: begin
        // Display of the just-latched plane starts while the next shift is issued.
        timer_d = TW'(BASE_ON) << shift_plane_q;
        if (enable) begin
          issue   = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      shift_start_d = 1'b1;
      frame_start_d = (nxt_row_q == '0) && (nxt_plane_q == '0);
      shift_row_d   = nxt_row_q;
      shift_plane_d = nxt_plane_q;
      if (nxt_plane_q == LAST_PLANE) begin
        nxt_plane_d = '0;
        nxt_row_d   = nxt_row_q + ROW_BITS'(1);
      end else begin
        nxt_plane_d = nxt_plane_q + 3'd1;
      end
    end

    panel_lat_d = (state_d == S_LATCH);
    panel_oe_d  = (timer_d == '0);
    busy_d      = (state_d != S_IDLE) || (timer_d != '0);
  end

  always_ff @(posedge osc25m) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      nxt_row_q     <= '0;
      nxt_plane_q   <= '0;
      shift_row_q   <= '0;
      shift_plane_q <= '0;
      timer_q       <= '0;
      blank_cnt_q   <= '0;
      panel_addr_q  <= '0;
      shift_start_q <= 1'b0;
      frame_start_q <= 1'b0;
      panel_lat_q   <= 1'b0;
      panel_oe_q    <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      nxt_row_q     <= nxt_row_d;
      nxt_plane_q   <= nxt_plane_d;
      shift_row_q   <= shift_row_d;
      shift_plane_q <= shift_plane_d;
      timer_q       <= timer_d;
      blank_cnt_q   <= blank_cnt_d;
      panel_addr_q  <= panel_addr_d;
      shift_start_q <= shift_start_d;
      frame_start_q <= frame_start_d;
      panel_lat_q   <= panel_lat_d;
      panel_oe_q    <= panel_oe_d;
      busy_q        <= busy_d;
    end
  end

  assign shift_start = shift_start_q;
  assign shift_row   = shift_row_q;
  assign shift_plane = shift_plane_q;
  assign panel_addr  = panel_addr_q;
  assign panel_lat   = panel_lat_q;
  assign panel_oe    = panel_oe_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: shifter responder with random latency plus a scan-order and
// timing reference model; honours HUB75_GHOST_BLANK_EN for the blank length.
module tb_hub75_scan_ctrl;
  localparam int ROW_BITS = 2;
  localparam int PLANES   = 3;
  localparam int BASE_ON  = 4;
  localparam int DEAD     = 4;
  localparam int NROWS    = 1 << ROW_BITS;
`ifdef HUB75_GHOST_BLANK_EN
  localparam int BL = DEAD;
`else
  localparam int BL = 1;
`endif

  logic osc25m = 1'b0;
  logic resetn = 1'b0, enable = 1'b0, shift_done = 1'b0;
  logic shift_start, panel_lat, panel_oe, frame_start, busy;
  logic [ROW_BITS-1:0] shift_row, panel_addr;
  logic [2:0] shift_plane;

  hub75_scan_ctrl #(.ROW_BITS(ROW_BITS), .PLANES(PLANES), .BASE_ON(BASE_ON), .DEAD(DEAD)) dut (
    .osc25m(osc25m), .resetn(resetn), .enable(enable),
    .shift_start(shift_start), .shift_row(shift_row), .shift_plane(shift_plane),
    .shift_done(shift_done), .panel_addr(panel_addr), .panel_lat(panel_lat),
    .panel_oe(panel_oe), .frame_start(frame_start), .busy(busy));

  always #5 osc25m = ~osc25m;

  int errors = 0, checks = 0, cyc = 0;
  // reference model state: scan index, open shift, event times
  int idx = 0, done_edge = 0, rise_s = -1000, fall_s = 0, lat_s = -1000, addr_chg_s = -1000;
  int cur_row = 0, cur_plane = 0, lat_row = 0, lat_plane = 0;
  bit open_s = 0, done_s = 0;
  logic prev_oe = 1'b1, prev_lat = 1'b0, prev_ss = 1'b0;
  logic [ROW_BITS-1:0] prev_addr = '0;
  int pend = 0, dly = 10;
  bit rand_dly = 0;

  task automatic step();
    logic en_e, done_in, rst_e;
    int exp_row, exp_plane, exp_lat, exp_len;
    bit exp_fs, exp_busy;
    en_e = enable; done_in = shift_done; rst_e = resetn;
    @(posedge osc25m); #1;
    cyc++;
    if (!rst_e) begin
      checks++;
      if ({panel_oe, panel_lat, panel_addr, shift_start, frame_start, busy} !== {1'b1, 1'b0, {ROW_BITS{1'b0}}, 3'b000}) begin
        errors++;
        $display("FAIL mon_reset got=%b exp=%b", {panel_oe, panel_lat, panel_addr, shift_start, frame_start, busy}, {1'b1, 1'b0, {ROW_BITS{1'b0}}, 3'b000});
      end
      idx = 0; open_s = 0; done_s = 0; rise_s = -1000; lat_s = -1000; addr_chg_s = -1000;
      lat_row = 0; prev_oe = 1'b1; prev_lat = 1'b0; prev_ss = 1'b0; prev_addr = '0;
      pend = 0; shift_done = 1'b0;
      return;
    end
    if (done_in && open_s && !done_s) begin
      done_s = 1; done_edge = cyc;
    end
    if (shift_start) begin
      exp_row = (idx / PLANES) % NROWS;
      exp_plane = idx % PLANES;
      exp_fs = (exp_row == 0) && (exp_plane == 0);
      checks++;
      if (shift_row !== ROW_BITS'(exp_row) || shift_plane !== 3'(exp_plane) || frame_start !== exp_fs || open_s || prev_ss) begin
        errors++;
        $display("FAIL mon_shift got=r%0d p%0d fs%0d exp=r%0d p%0d fs%0d open=%0d prev=%0d", shift_row, shift_plane, frame_start, exp_row, exp_plane, exp_fs, open_s, prev_ss);
      end
      cur_row = exp_row; cur_plane = exp_plane; open_s = 1; done_s = 0; idx++;
    end else begin
      if (frame_start) begin
        checks++; errors++;
        $display("FAIL mon_frame_alone got=1 exp=0");
      end
      if (open_s && !done_s) begin
        checks++;
        if (shift_row !== ROW_BITS'(cur_row) || shift_plane !== 3'(cur_plane)) begin
          errors++;
          $display("FAIL mon_shift_stable got=r%0d p%0d exp=r%0d p%0d", shift_row, shift_plane, cur_row, cur_plane);
        end
      end
    end
    exp_busy = !panel_oe || open_s;
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL mon_busy got=%0d exp=%0d cyc=%0d", busy, exp_busy, cyc);
    end
    if (cyc == lat_s + 1) begin
      checks++;
      if (panel_oe !== 1'b0 || shift_start !== en_e) begin
        errors++;
        $display("FAIL mon_after_latch got=oe%0d ss%0d exp=oe0 ss%0d", panel_oe, shift_start, en_e);
      end
    end
    if (panel_addr !== prev_addr) addr_chg_s = cyc;
    if (panel_lat) begin
      checks++;
      if (panel_oe !== 1'b1 || prev_lat) begin
        errors++;
        $display("FAIL mon_latch_shape got=oe%0d prevlat%0d exp=oe1 prevlat0", panel_oe, prev_lat);
      end
      if (!prev_lat) begin
        checks++;
        if (!open_s || !done_s) begin
          errors++;
          $display("FAIL mon_latch_unexpected got=open%0d done%0d exp=open1 done1", open_s, done_s);
        end else begin
          exp_lat = ((done_edge > rise_s + 1) ? done_edge : rise_s + 1) + BL;
          if (cyc != exp_lat || panel_addr !== ROW_BITS'(cur_row) || (cur_row != lat_row && addr_chg_s != cyc - BL)) begin
            errors++;
            $display("FAIL mon_latch got=t%0d a%0d chg%0d exp=t%0d a%0d chg%0d", cyc, panel_addr, addr_chg_s, exp_lat, cur_row, cyc - BL);
          end
        end
        lat_s = cyc; lat_row = cur_row; lat_plane = cur_plane; open_s = 0;
      end
    end
    if (!panel_oe && prev_oe) fall_s = cyc;
    if (panel_oe && !prev_oe) begin
      rise_s = cyc;
      exp_len = BASE_ON << lat_plane;
      checks++;
      if (rise_s - fall_s != exp_len) begin
        errors++;
        $display("FAIL mon_display_len got=%0d exp=%0d", rise_s - fall_s, exp_len);
      end
    end
    prev_oe = panel_oe; prev_lat = panel_lat; prev_ss = shift_start; prev_addr = panel_addr;
    shift_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) shift_done = 1'b1;
    end
    if (shift_start) pend = rand_dly ? int'($urandom_range(1, 25)) : dly;
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; shift_done = 1'b0;
    repeat (3) begin
      step();
      checks++; if (panel_oe !== 1'b1)   begin errors++; $display("FAIL reset_oe got=%0d exp=1", panel_oe); end
      checks++; if (panel_lat !== 1'b0)  begin errors++; $display("FAIL reset_lat got=%0d exp=0", panel_lat); end
      checks++; if (panel_addr !== '0)   begin errors++; $display("FAIL reset_addr got=%0d exp=0", panel_addr); end
      checks++; if (shift_start !== 1'b0) begin errors++; $display("FAIL reset_shift_start got=%0d exp=0", shift_start); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    end
  endtask

  task automatic test_first_row();
    int t_en, t_ss, n, low;
    enable = 1'b0; resetn = 1'b1;
    step(); step();
    checks++; if (busy !== 1'b0 || panel_oe !== 1'b1) begin errors++; $display("FAIL idle_outputs got=b%0d oe%0d exp=b0 oe1", busy, panel_oe); end
    dly = 10; enable = 1'b1; t_en = cyc;
    step();
    checks++;
    if (shift_start !== 1'b1 || cyc != t_en + 1 || shift_row !== '0 || shift_plane !== 3'd0 || frame_start !== 1'b1) begin
      errors++; $display("FAIL first_shift got=ss%0d r%0d p%0d fs%0d exp=ss1 r0 p0 fs1", shift_start, shift_row, shift_plane, frame_start);
    end
    t_ss = cyc; n = 0;
    while (!panel_lat && n < 60) begin step(); n++; end
    checks++; if (!panel_lat || cyc != t_ss + 11 + BL) begin errors++; $display("FAIL first_latch_time got=%0d exp=%0d", cyc, t_ss + 11 + BL); end
    step();
    checks++;
    if (panel_lat !== 1'b0 || panel_oe !== 1'b0 || shift_start !== 1'b1 || shift_row !== '0 || shift_plane !== 3'd1) begin
      errors++; $display("FAIL overlap_shift got=lat%0d oe%0d ss%0d r%0d p%0d exp=lat0 oe0 ss1 r0 p1", panel_lat, panel_oe, shift_start, shift_row, shift_plane);
    end
    low = 0; n = 0;
    while (panel_oe === 1'b0 && n < 100) begin low++; step(); n++; end
    checks++; if (low != BASE_ON) begin errors++; $display("FAIL plane0_on got=%0d exp=%0d", low, BASE_ON); end
  endtask

  task automatic test_wait_plane2();
    int n, low, rise;
    dly = 2; n = 0;
    while (!(panel_lat && lat_plane == 2) && n < 300) begin step(); n++; end
    checks++; if (!panel_lat || lat_plane != 2) begin errors++; $display("FAIL plane2_latch_seen got=%0d exp=1", panel_lat); end
    step();
    low = 0; n = 0;
    while (panel_oe === 1'b0 && n < 100) begin low++; step(); n++; end
    checks++; if (low != BASE_ON << 2) begin errors++; $display("FAIL plane2_on got=%0d exp=%0d", low, BASE_ON << 2); end
    rise = cyc; n = 0;
    while (!panel_lat && n < 40) begin step(); n++; end
    checks++; if (!panel_lat || cyc != rise + 1 + BL) begin errors++; $display("FAIL wait_latch_gap got=%0d exp=%0d", cyc - rise, 1 + BL); end
  endtask

  task automatic test_sequence();
    int frames;
    frames = 0; rand_dly = 1;
    for (int i = 0; i < 1800; i++) begin
      if (i >= 1200 && $urandom_range(0, 49) == 0) enable = ~enable;
      step();
      if (shift_start && shift_row == '0 && shift_plane == 3'd0) begin
        frames++;
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL wrap_frame_start got=%0d exp=1", frame_start); end
      end
    end
    enable = 1'b1; rand_dly = 0;
    checks++; if (frames < 2) begin errors++; $display("FAIL frame_count got=%0d exp=2", frames); end
  endtask

  task automatic test_enable_drop();
    int n, low;
    bit bad_ss, bad_busy;
    logic busy_last;
    dly = 10; n = 0;
    while (!(shift_start && shift_row == ROW_BITS'(1) && shift_plane == 3'd1) && n < 3000) begin step(); n++; end
    checks++; if (!shift_start) begin errors++; $display("FAIL find_row1_plane1 got=0 exp=1"); end
    repeat (3) step();
    enable = 1'b0; n = 0;
    while (!panel_lat && n < 100) begin step(); n++; end
    checks++; if (!panel_lat || panel_addr !== ROW_BITS'(1)) begin errors++; $display("FAIL drop_latch got=lat%0d a%0d exp=lat1 a1", panel_lat, panel_addr); end
    step();
    checks++; if (panel_oe !== 1'b0 || shift_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL drop_display got=oe%0d ss%0d b%0d exp=oe0 ss0 b1", panel_oe, shift_start, busy); end
    low = 0; n = 0; busy_last = 1'b0;
    while (panel_oe === 1'b0 && n < 100) begin low++; busy_last = busy; step(); n++; end
    checks++; if (low != BASE_ON << 1) begin errors++; $display("FAIL drop_on got=%0d exp=%0d", low, BASE_ON << 1); end
    checks++; if (busy_last !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL drop_busy_fall got=%0d%0d exp=10", busy_last, busy); end
    bad_ss = 0; bad_busy = 0;
    repeat (30) begin step(); if (shift_start) bad_ss = 1; if (busy) bad_busy = 1; end
    checks++; if (bad_ss || bad_busy) begin errors++; $display("FAIL drop_quiet got=ss%0d b%0d exp=ss0 b0", bad_ss, bad_busy); end
  endtask

  task automatic test_resume();
    dly = 30; enable = 1'b1;
    step();
    checks++;
    if (shift_start !== 1'b1 || shift_row !== ROW_BITS'(1) || shift_plane !== 3'd2 || frame_start !== 1'b0) begin
      errors++; $display("FAIL resume got=ss%0d r%0d p%0d fs%0d exp=ss1 r1 p2 fs0", shift_start, shift_row, shift_plane, frame_start);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit bad;
    repeat (3) step();
    resetn = 1'b0;
    step(); step();
    checks++; if (panel_oe !== 1'b1 || panel_lat !== 1'b0 || busy !== 1'b0 || shift_start !== 1'b0) begin errors++; $display("FAIL midshift_reset got=oe%0d lat%0d b%0d ss%0d exp=oe1 lat0 b0 ss0", panel_oe, panel_lat, busy, shift_start); end
    resetn = 1'b1; enable = 1'b0;
    step();
    shift_done = 1'b1;
    bad = 0;
    repeat (20) begin step(); if (panel_lat || shift_start || busy || !panel_oe) bad = 1; end
    checks++; if (bad) begin errors++; $display("FAIL stale_done got=1 exp=0"); end
    dly = 3; enable = 1'b1;
    step();
    checks++;
    if (shift_start !== 1'b1 || shift_row !== '0 || shift_plane !== 3'd0 || frame_start !== 1'b1) begin
      errors++; $display("FAIL restart got=ss%0d r%0d p%0d fs%0d exp=ss1 r0 p0 fs1", shift_start, shift_row, shift_plane, frame_start);
    end
    n = 0;
    while (panel_oe !== 1'b0 && n < 100) begin step(); n++; end
    checks++; if (panel_oe !== 1'b0) begin errors++; $display("FAIL find_display got=%0d exp=0", panel_oe); end
    resetn = 1'b0;
    step();
    checks++; if (panel_oe !== 1'b1 || busy !== 1'b0 || panel_lat !== 1'b0) begin errors++; $display("FAIL middisplay_reset got=oe%0d b%0d lat%0d exp=oe1 b0 lat0", panel_oe, busy, panel_lat); end
    resetn = 1'b1; enable = 1'b0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_wait_plane2();
    test_sequence();
    test_enable_drop();
    test_resume();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
